bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Parametrised round-robin bus arbiter with split-transaction tracking for the serial system bus. It replaces the fixed two-master priority arbitration with arbitration over NUM_MASTERS requesters. It parks a master whose transaction a slave splits, and re-grants that master with top priority when the slave signals completion. It sits inside the bus interconnect, between the master ports' breq/bgrant/split lines and the address-decoder/mux control.

## Interface
- NUM_MASTERS, 2: number of requesting masters; legal range 2–8.
- HOLD_LIMIT, 1024: maximum cycles one owner may keep the bus; used only with ARB_TIMEOUT_EN.
- OW: derived, $clog2(NUM_MASTERS); not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- breq  input  NUM_MASTERS  per-master bus request; held high for the whole transaction.
- bgrant  output  NUM_MASTERS  one-hot or zero grant, registered.
- owner  output  OW  index of the granted master; valid only while bus_busy=1.
- bus_busy  output  1  some bit of bgrant is high.
- s_split  input  1  one-cycle pulse: the addressed slave splits the current owner's transaction.
- s_split_done  input  1  one-cycle pulse: the split slave is ready to resume.
- m_split  output  NUM_MASTERS  level; high for the parked master (at most one bit).
- split_grant  output  1  one-cycle pulse, coincident with the first cycle of a re-grant to the parked master.
- timeout  output  1  one-cycle pulse on a forced revoke; tied 0 without ARB_TIMEOUT_EN.

## Operation
- FSM states: IDLE, OWNED, HANDOVER.
- IDLE: if any eligible breq is high, pick a winner, set bgrant[winner]=1 and owner=winner, and go to OWNED.
  - A master is eligible when its breq is high and its m_split bit is low.
  - Priority 1: if a resume is pending and the parked master's breq is high, the parked master wins. Assert split_grant for that cycle, clear m_split and the pending flag.
  - Priority 2: otherwise round-robin. Search from last_owner+1 modulo NUM_MASTERS; the first eligible master wins.
  - Update last_owner on every grant.
- OWNED, breq[owner] low: clear bgrant and go to HANDOVER.
- OWNED, s_split=1: clear bgrant, set m_split[owner], latch split_idx=owner, and go to HANDOVER.
  - If a split is already outstanding, s_split is ignored; only one split is tracked.
- HANDOVER: one dead cycle, with no grant and the mux idle. Always go to IDLE.
- s_split_done is accepted in any state while a split is outstanding.
  - It sets resume_pending, which is honoured at the next IDLE arbitration.
  - If no split is outstanding, it is ignored.
- Parked master drops breq before resume: clear m_split, split_idx validity and resume_pending on the next edge. This is a cancel.
- s_split in IDLE or HANDOVER is ignored.
- Reset values: bgrant=0, owner=0, bus_busy=0, m_split=0, split_grant=0, timeout=0, state=IDLE, no split outstanding, last_owner=NUM_MASTERS-1. Master 0 therefore has first priority after reset.

## Timing
- Request-to-grant latency: breq high in IDLE at edge t gives bgrant high after edge t. That is 1 cycle from a registered sample.
- Release: breq[owner] sampled low at edge t gives bgrant low after t, HANDOVER during t→t+1, and the earliest new grant after edge t+2.
- Split: s_split sampled at edge t gives bgrant low and m_split high after t. Same HANDOVER rule applies.
- Resume: s_split_done at t, with the bus idle, gives IDLE at t+1 and the re-grant plus split_grant after edge t+1.
  - If the bus is owned, the re-grant follows that owner's release and HANDOVER.
- Simultaneous events in one cycle:
  - Release and s_split together: split takes precedence; m_split is set.
  - s_split_done and cancel together: cancel wins.
- Async rst mid-transfer: every output drops immediately; no grant is issued until rst is deasserted and one edge has passed.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter, $clog2(HOLD_LIMIT+1) bits wide, clears on every grant and increments each OWNED cycle.
  - When it reaches HOLD_LIMIT, bgrant is revoked as for a release, timeout pulses for one cycle, and the FSM goes to HANDOVER.
  - A revoke has no effect on m_split.
- ARB_TIMEOUT_EN undefined: no counter is instantiated, timeout=0 constant, and an owner may hold the bus indefinitely.

## Test plan
- NUM_MASTERS=4: breq=4'b1111 held, each master releases after 3 cycles. Required grant order is 0,1,2,3,0, with exactly one dead cycle between grants.
- Master 1 granted, s_split pulse. Required response:
  - m_split=4'b0010 and bgrant=0 the next cycle.
  - Master 2, also requesting, is granted 2 cycles later.
  - breq[1] held high does not win while m_split[1]=1.
- Split outstanding on master 1, master 3 owns the bus, s_split_done pulsed. Required response:
  - No grant change until master 3 releases.
  - After HANDOVER, bgrant=4'b0010 with split_grant=1 for exactly that cycle, and m_split=0.
- Parked master 1 drops breq, with s_split_done on the same cycle. Required response: m_split=0 next edge, no split_grant, resume discarded.
- rst asserted while master 2 is granted and master 0 is parked. Required response:
  - All outputs 0 immediately.
  - After release of rst with breq=4'b0101, master 0 is granted first.
- With ARB_TIMEOUT_EN and HOLD_LIMIT=16, master 0 holds breq for 40 cycles. Required response:
  - bgrant drops after 16 OWNED cycles, with a one-cycle timeout pulse.
  - Master 1 is granted if requesting.
  - Without the macro, the grant persists for all 40 cycles and timeout stays 0.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter with single split-transaction tracking; ARB_TIMEOUT_EN adds a hold-limit revoke
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int HOLD_LIMIT = 1024,
  localparam int OW = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] breq,
  output logic [NUM_MASTERS-1:0] bgrant,
  output logic [OW-1:0]          owner,
  output logic                   bus_busy,
  input  logic                   s_split,
  input  logic                   s_split_done,
  output logic [NUM_MASTERS-1:0] m_split,
  output logic                   split_grant,
  output logic                   timeout
);
  localparam logic [1:0] IDLE = 2'd0, OWNED = 2'd1, HANDOVER = 2'd2;
  logic [1:0] state;
  logic [OW-1:0] last_owner, split_idx, rr_win, cand, win;
  logic split_valid, resume_pending, rr_hit, res_win, grant, split_c, release_c, revoke;
  logic [NUM_MASTERS-1:0] elig;
  assign m_split = split_valid ? NUM_MASTERS'(1) << split_idx : '0;
  assign bus_busy = |bgrant;
  assign elig = breq & ~m_split;
  assign res_win = resume_pending && breq[split_idx];
  // descending scan so the nearest eligible master after last_owner is written last
  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    cand = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = OW'((int'(last_owner) + i) % NUM_MASTERS);
      if (elig[cand]) begin
        rr_win = cand;
        rr_hit = 1'b1;
      end
    end
  end
  assign win = res_win ? split_idx : rr_win;
  assign grant = state == IDLE && (res_win || rr_hit);
  assign split_c = state == OWNED && s_split && !split_valid;
  assign release_c = state == OWNED && !breq[owner];
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_LIMIT + 1);
  logic [CW-1:0] hold_cnt;
  assign revoke = state == OWNED && hold_cnt == CW'(HOLD_LIMIT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      hold_cnt <= grant ? '0 : state == OWNED ? hold_cnt + 1'b1 : hold_cnt;
      timeout <= revoke && !split_c && !release_c;
    end
  end
`else
  assign revoke = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bgrant <= '0;
      owner <= '0;
      last_owner <= OW'(NUM_MASTERS - 1);
      split_grant <= 1'b0;
    end else begin
      split_grant <= grant && res_win;
      if (grant) begin
        state <= OWNED;
        bgrant <= NUM_MASTERS'(1) << win;
        owner <= win;
        last_owner <= win;
      end else if (split_c || release_c || revoke) begin
        state <= HANDOVER;
        bgrant <= '0;
      end else if (state == HANDOVER) begin
        state <= IDLE;
      end
    end
  end
  // a resume grant or a cancel both retire the split; cancel also discards a same-cycle done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      split_valid <= 1'b0;
      split_idx <= '0;
      resume_pending <= 1'b0;
    end else if ((grant && res_win) || (split_valid && !breq[split_idx])) begin
      split_valid <= 1'b0;
      resume_pending <= 1'b0;
    end else if (split_valid && s_split_done) begin
      resume_pending <= 1'b1;
    end else if (split_c) begin
      split_valid <= 1'b1;
      split_idx <= owner;
      resume_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed scenarios plus random traffic checked every cycle against a behavioural arbiter model
module tb_bus_arbiter_rr;
  localparam int N = 4;
  localparam int OW = 2;
  localparam int HOLD = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] breq = '0;
  logic s_split = 1'b0, s_split_done = 1'b0;
  logic [N-1:0] bgrant, m_split;
  logic [OW-1:0] owner;
  logic bus_busy, split_grant, timeout;
  int checks = 0, errors = 0;

  bus_arbiter_rr #(.NUM_MASTERS(N), .HOLD_LIMIT(HOLD)) dut (
    .clk(clk), .rst(rst), .breq(breq), .bgrant(bgrant), .owner(owner), .bus_busy(bus_busy),
    .s_split(s_split), .s_split_done(s_split_done), .m_split(m_split),
    .split_grant(split_grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // model: owner index or -1, dead-cycle flag, parked index or -1, pending resume
  int m_own, m_park, m_last, m_hold;
  bit m_dead, m_res, m_sg, m_to;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_park = -1; m_last = N - 1; m_hold = 0;
      m_dead = 0; m_res = 0; m_sg = 0; m_to = 0;
    end else begin
      int op, w;
      op = m_park; m_sg = 0; m_to = 0; w = -1;
      if (m_dead) m_dead = 0;
      else if (m_own < 0) begin
        if (m_res && m_park >= 0 && breq[m_park]) begin
          w = m_park; m_sg = 1; m_park = -1; m_res = 0;
        end else
          for (int k = 1; k <= N; k++)
            if (w < 0 && breq[(m_last + k) % N] && (m_last + k) % N != m_park) w = (m_last + k) % N;
        if (w >= 0) begin m_own = w; m_last = w; m_hold = 0; end
      end else if (s_split && m_park < 0) begin
        m_park = m_own; m_res = 0; m_own = -1; m_dead = 1;
      end else if (!breq[m_own]) begin
        m_own = -1; m_dead = 1;
      end else begin
        m_hold++;
`ifdef ARB_TIMEOUT_EN
        if (m_hold == HOLD) begin m_own = -1; m_dead = 1; m_to = 1; end
`endif
      end
      if (op >= 0 && m_park == op) begin
        if (!breq[op]) begin m_park = -1; m_res = 0; end
        else if (s_split_done) m_res = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      logic [N-1:0] eg, em;
      eg = '0; em = '0;
      if (m_own >= 0) eg[m_own] = 1'b1;
      if (m_park >= 0) em[m_park] = 1'b1;
      checks++;
      if (bgrant !== eg || bus_busy !== (m_own >= 0) || (m_own >= 0 && owner !== m_own[OW-1:0]) ||
          m_split !== em || split_grant !== m_sg || timeout !== m_to) begin
        errors++;
        $display("FAIL model t=%0t bgrant=%b/%b owner=%0d/%0d busy=%b m_split=%b/%b split_grant=%b/%b timeout=%b/%b",
                 $time, bgrant, eg, owner, m_own, bus_busy, m_split, em, split_grant, m_sg, timeout, m_to);
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; breq = '0; s_split = 1'b0; s_split_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_grant(output int gap);
    gap = 0;
    while (bgrant == '0 && gap < 64) begin
      @(negedge clk);
      gap++;
    end
    if (bgrant == '0) chk("wait_grant_bound", 32'(gap), 32'(-1));
  endtask

  initial begin
    int gap, run0, to_seen, sg_seen, exp_o[5];
    bit stop0, saw1;
    exp_o = '{0, 1, 2, 3, 0};
    do_reset();
    chk("rst_bgrant", 32'(bgrant), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(bus_busy), 0);
    chk("rst_m_split", 32'(m_split), 0);
    chk("rst_split_grant", 32'(split_grant), 0);
    chk("rst_timeout", 32'(timeout), 0);
    breq = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_grant(gap);
      if (g > 0) chk("rr_gap", 32'(gap), 2);
      chk("rr_order", 32'(owner), 32'(exp_o[g]));
      repeat (2) @(negedge clk);
      breq[owner] = 1'b0;
      @(negedge clk);
      breq = 4'b1111;
    end
    do_reset();
    breq = 4'b0010;
    wait_grant(gap);
    chk("split_pre_owner", 32'(owner), 1);
    breq = 4'b0110; s_split = 1'b1;
    @(negedge clk); s_split = 1'b0;
    chk("split_m_split", 32'(m_split), 32'b0010);
    chk("split_bgrant", 32'(bgrant), 0);
    @(negedge clk);
    chk("split_dead", 32'(bgrant), 0);
    @(negedge clk);
    chk("split_next", 32'(bgrant), 32'b0100);
    chk("split_still_parked", 32'(m_split), 32'b0010);
    breq = 4'b1010;
    @(negedge clk);
    wait_grant(gap);
    chk("parked_skipped", 32'(owner), 3);
    s_split_done = 1'b1;
    @(negedge clk); s_split_done = 1'b0;
    repeat (3) begin
      chk("resume_waits", 32'(bgrant), 32'b1000);
      @(negedge clk);
    end
    breq = 4'b0010;
    @(negedge clk);
    chk("resume_handover", 32'(bgrant), 0);
    @(negedge clk);
    chk("resume_idle", 32'(bgrant), 0);
    @(negedge clk);
    chk("resume_grant", 32'(bgrant), 32'b0010);
    chk("resume_split_grant", 32'(split_grant), 1);
    chk("resume_m_split", 32'(m_split), 0);
    @(negedge clk);
    chk("resume_pulse_end", 32'(split_grant), 0);
    breq = 4'b0110; s_split = 1'b1;
    @(negedge clk); s_split = 1'b0;
    chk("cancel_parked", 32'(m_split), 32'b0010);
    wait_grant(gap);
    chk("cancel_owner", 32'(owner), 2);
    breq = 4'b0100; s_split_done = 1'b1;
    @(negedge clk); s_split_done = 1'b0;
    chk("cancel_m_split", 32'(m_split), 0);
    breq = 4'b0000; sg_seen = 0;
    repeat (6) begin @(negedge clk); sg_seen += int'(split_grant); end
    breq = 4'b0010;
    wait_grant(gap);
    sg_seen += int'(split_grant);
    chk("cancel_no_split_grant", 32'(sg_seen), 0);
    do_reset();
    breq = 4'b0001;
    wait_grant(gap);
    breq = 4'b0101; s_split = 1'b1;
    @(negedge clk); s_split = 1'b0;
    wait_grant(gap);
    chk("rst_pre_owner", 32'(owner), 2);
    chk("rst_pre_parked", 32'(m_split), 32'b0001);
    #1 rst = 1'b1;
    #1;
    chk("arst_bgrant", 32'(bgrant), 0);
    chk("arst_busy", 32'(bus_busy), 0);
    chk("arst_m_split", 32'(m_split), 0);
    chk("arst_owner", 32'(owner), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("arst_no_early_grant", 32'(bgrant), 0);
    @(negedge clk);
    chk("arst_first_grant", 32'(bgrant), 32'b0001);
    do_reset();
    breq = 4'b0011; run0 = 0; to_seen = 0; stop0 = 0; saw1 = 0;
    repeat (40) begin
      @(negedge clk);
      if (bgrant == 4'b0001 && !stop0) run0++; else stop0 = 1;
      if (bgrant == 4'b0010) saw1 = 1;
      to_seen += int'(timeout);
    end
`ifdef ARB_TIMEOUT_EN
    chk("hold_run", 32'(run0), HOLD);
    chk("hold_timeouts", 32'(to_seen), 2);
    chk("hold_next_master", 32'(saw1), 1);
`else
    chk("hold_run", 32'(run0), 40);
    chk("hold_timeouts", 32'(to_seen), 0);
    chk("hold_next_master", 32'(saw1), 0);
`endif
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++)
        breq[i] = !breq[i] ? ($urandom % 4 == 0) : bgrant[i] ? ($urandom % 4 != 0) : ($urandom % 32 != 0);
      s_split = bus_busy && ($urandom % 6 == 0);
      s_split_done = ($urandom % 6 == 0);
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
